// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
//
// Multi-channel push-button conditioner for the KEY pins. Each channel is
// synchronized into the Clk domain, normalized so that 1 means "pressed",
// and debounced by a consecutive-sample counter FSM. Outputs are a clean
// pressed level, one-cycle press/release strobes and a sticky press flag
// that the consumer clears explicitly.
//
// Parameters
//   N_KEYS          number of independent key channels
//   DEBOUNCE_CYCLES consecutive stable samples needed to accept a change
//                   (1 .. 2^24)
//   ACTIVE_LOW      1: pin low = pressed, 0: pin high = pressed
//
// Ports
//   Clk            system clock, all state on the rising edge
//   Reset_n        asynchronous active-low reset
//   key_raw        raw asynchronous key pins
//   key_level      debounced level, 1 = pressed
//   press_pulse    one-cycle strobe coincident with key_level rising
//   release_pulse  one-cycle strobe coincident with key_level falling
//   event_sticky   set by press_pulse, held until cleared
//   event_clr      synchronous per-channel clear of event_sticky
//                  (a simultaneous press_pulse wins)
// ---------------------------------------------------------------------------
module key_debounce #(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] event_sticky,
  input  logic [N_KEYS-1:0] event_clr
);

  localparam int               CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ACCEPT = CNT_W'(DEBOUNCE_CYCLES);
  // Synchronizer idle value is the electrical level of a released key.
  localparam logic [N_KEYS-1:0] PIN_IDLE  = {N_KEYS{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // Counter never exceeds CNT_ACCEPT-1 before acceptance resets it, so the
  // increment cannot wrap.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return c + CNT_W'(1);
  endfunction

  // True when the current sample is the DEBOUNCE_CYCLES-th consecutive one.
  function automatic logic cnt_accept(input logic [CNT_W-1:0] c);
    return (cnt_inc(c) == CNT_ACCEPT);
  endfunction

  logic [N_KEYS-1:0] sync_p0;
  logic [N_KEYS-1:0] sync_p1;
  logic [N_KEYS-1:0] s_p2;

  // ---- stage p0/p1: two-flop synchronizer ----
  // ---- stage p2: polarity normalization, s = 1 means pressed ----
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_p0 <= PIN_IDLE;
      sync_p1 <= PIN_IDLE;
      s_p2    <= '0;
    end else begin
      sync_p0 <= key_raw;
      sync_p1 <= sync_p0;
      s_p2    <= sync_p1 ^ PIN_IDLE;
    end
  end

  // ---- stage p3: per-channel debounce FSM and registered outputs ----
  for (genvar k = 0; k < N_KEYS; k++) begin : g_ch
    state_t           state_p3, state_d;
    logic [CNT_W-1:0] cnt_p3, cnt_d;
    logic             level_p3, level_d;
    logic             press_p3, press_d;
    logic             release_p3, release_d;
    logic             sticky_p3, sticky_d;

    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        state_p3   <= RELEASED;
        cnt_p3     <= '0;
        level_p3   <= 1'b0;
        press_p3   <= 1'b0;
        release_p3 <= 1'b0;
        sticky_p3  <= 1'b0;
      end else begin
        state_p3   <= state_d;
        cnt_p3     <= cnt_d;
        level_p3   <= level_d;
        press_p3   <= press_d;
        release_p3 <= release_d;
        sticky_p3  <= sticky_d;
      end
    end

    always_comb begin
      state_d   = state_p3;
      cnt_d     = cnt_p3;
      level_d   = level_p3;
      press_d   = 1'b0;
      release_d = 1'b0;
      // Set wins over clear; uses the registered strobe so the flag
      // follows the press_pulse cycle.
      sticky_d  = press_p3 | (sticky_p3 & ~event_clr[k]);

      unique case (state_p3)
        // RELEASED holds count 0, so it shares the PRESS_WAIT arithmetic;
        // this also gives first-sample acceptance when DEBOUNCE_CYCLES=1.
        RELEASED, PRESS_WAIT: begin
          if (s_p2[k]) begin
            if (cnt_accept(cnt_p3)) begin
              state_d = PRESSED;
              cnt_d   = '0;
              level_d = 1'b1;
              press_d = 1'b1;
            end else begin
              state_d = PRESS_WAIT;
              cnt_d   = cnt_inc(cnt_p3);
            end
          end else begin
            state_d = RELEASED;
            cnt_d   = '0;
          end
        end
        PRESSED, RELEASE_WAIT: begin
          if (!s_p2[k]) begin
            if (cnt_accept(cnt_p3)) begin
              state_d   = RELEASED;
              cnt_d     = '0;
              level_d   = 1'b0;
              release_d = 1'b1;
            end else begin
              state_d = RELEASE_WAIT;
              cnt_d   = cnt_inc(cnt_p3);
            end
          end else begin
            state_d = PRESSED;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = RELEASED;
          cnt_d   = '0;
          level_d = 1'b0;
        end
      endcase
    end

    assign key_level[k]     = level_p3;
    assign press_pulse[k]   = press_p3;
    assign release_pulse[k] = release_p3;
    assign event_sticky[k]  = sticky_p3;
  end

endmodule
